vga_capture: RTL
================

# vga_capture

Receiving end of the VGA pixel bus. Samples `h_sync`, `v_sync` and 2-bit R/G/B at the pixel clock, recovers line/frame timing, and verifies it against configured timing. Once locked, it emits each active pixel with its (x, y) coordinate and a frame-start strobe. Used as a loop-back checker and capture front end for the display pipeline.

## Interface
- `H_PIXELS`, 640, active pixels per line
- `V_PIXELS`, 480, active lines per frame
- `H_PULSE`, 208, h_sync pulse width (pixels)
- `H_BPORCH`, 336, horizontal back porch (pixels)
- `H_PERIOD`, 1312, total pixels per line
- `V_PULSE`, 3, v_sync pulse width (lines)
- `V_BPORCH`, 38, vertical back porch (lines)
- `V_PERIOD`, 522, total lines per frame
- `H_POLAR`, 1, 1 means h_sync is asserted low
- `V_POLAR`, 1, 1 means v_sync is asserted low
- `LOCK_FRAMES`, 2, consecutive good frames required to lock (1..15)

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous, active-low reset
- `h_sync`  in  1  horizontal sync, polarity set by `H_POLAR`
- `v_sync`  in  1  vertical sync, polarity set by `V_POLAR`
- `R`, `G`, `B`  in  2 each  pixel colour
- `pix`  out  6  captured pixel {R,G,B}; reset 0
- `x`  out  10  active column; reset 0
- `y`  out  9  active row; reset 0
- `pix_valid`  out  1  pix/x/y valid; reset 0
- `frame_start`  out  1  one-cycle pulse with pixel (0,0); reset 0
- `locked`  out  1  timing verified; reset 0
- `err_h`  out  1  sticky line-length error; reset 0
- `err_v`  out  1  sticky frame-length error; reset 0
- `blank_err_cnt`  out  16  blanking-violation count; reset 0

## Operation
- Stage 1: register sync inputs (normalised to active-high using `*_POLAR`) and RGB. Keep a one-cycle-delayed copy of each sync for edge detection.
- H leading edge: a stage-1 sync sample is asserted and the previous sample is deasserted. Pixel counter `hc` (12 bits) loads 0 on the edge sample and otherwise increments. It saturates at 4095.
- Line counter `vc` (11 bits): increments on each H leading edge. On a V leading edge it loads 0, and that line is line 0. If both edges occur in the same cycle, the V edge takes priority.
- Active window: `hc` in [H_PULSE+H_BPORCH, H_PULSE+H_BPORCH+H_PIXELS-1] and `vc` in [V_PULSE+V_BPORCH, V_PULSE+V_BPORCH+V_PIXELS-1]. Then x = hc-(H_PULSE+H_BPORCH) and y = vc-(V_PULSE+V_BPORCH).
- Line check: on each H leading edge, the previous line length (`hc`+1) must equal `H_PERIOD`. Also, if `hc` reaches 2*H_PERIOD with no edge, that is a timeout, and it counts as a line error.
- Frame check: on each V leading edge, the previous frame line count (`vc`+1) must equal `V_PERIOD`.
- FSM states:
  - SEARCH (reset state): go to VERIFY on a V edge and clear the good-frame count.
  - VERIFY: on each V edge with no error this frame, increment the good-frame count. When it reaches `LOCK_FRAMES`, go to LOCKED. Any line or frame error returns to SEARCH.
  - LOCKED: `locked`=1. Any line or frame error returns to SEARCH, and `locked` drops.
- `err_h` is set by a line error in VERIFY or LOCKED. `err_v` is set by a frame error in VERIFY or LOCKED. Both clear only on reset.
- `pix_valid`=1 only in LOCKED and inside the active window. `frame_start`=1 when x=0, y=0 and `pix_valid`=1. When `pix_valid`=0, `pix`, `x` and `y` hold their last values.
- Frames are only counted as good from the first complete frame after entering VERIFY.

## Timing
- Latency is 2 cycles: an RGB value present at input edge n appears on `pix` after edge n+2, together with its x, y and `pix_valid`.
- `locked` rises 2 cycles after the stage-1 V edge sample that completes the `LOCK_FRAMES`-th good frame. The first `pix_valid` follows at frame line `V_PULSE+V_BPORCH`.
- An error detected on an edge sample deasserts `locked` and `pix_valid` 2 cycles after that sample, with no partial-line output afterwards.
- Reset assertion clears all state and outputs immediately (asynchronously). After release, the block starts in SEARCH.

## Configuration
- `VGA_CAPTURE_BLANK_CHECK_EN` defined: in LOCKED, each stage-1 sample outside the active window with nonzero RGB increments `blank_err_cnt`. The count saturates at 65535 and is cleared only by reset.
- Not defined: the check logic is omitted and `blank_err_cnt` is constant 0.

## Test plan
- Default-timing source, RGB = {x[1:0], y[1:0], 2'b01} → `locked`=1 after 2 good frames; in frame 3, pixel (639,479) captured as 6'b111101; exactly 307200 `pix_valid` cycles per frame.
- Single line 1311 pixels long in a locked frame → `err_h`=1, `locked`=0, `pix_valid`=0 within 2 cycles; relock after 2 further good frames; `err_h` stays 1.
- Frame with 521 lines → `err_v`=1 at that V edge; return to SEARCH.
- h_sync stuck deasserted → timeout at `hc`=2624, `err_h`=1, `locked`=0.
- `rst_n` pulsed low mid-line while locked → all outputs 0 immediately; resync after 2 frames.
- With macro defined, RGB=6'h3F for 5 samples during horizontal front porch while locked → `blank_err_cnt`=5. Without the macro → `blank_err_cnt`=0.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA pixel bus.
// Registers sync/RGB, recovers pixel and line counters from the sync leading
// edges, checks line/frame lengths against the configured timing, and once
// locked emits every active pixel with its (x, y) coordinate.
// Optional feature macro: VGA_CAPTURE_BLANK_CHECK_EN counts non-black samples
// seen outside the active window while locked (blank_err_cnt).
// Pipeline: stage 1 = input registers, stage 2 = counters/FSM, stage 3 = outputs.
module vga_capture #(
  parameter int H_PIXELS    = 640,
  parameter int V_PIXELS    = 480,
  parameter int H_PULSE     = 208,
  parameter int H_BPORCH    = 336,
  parameter int H_PERIOD    = 1312,
  parameter int V_PULSE     = 3,
  parameter int V_BPORCH    = 38,
  parameter int V_PERIOD    = 522,
  parameter int H_POLAR     = 1,
  parameter int V_POLAR     = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [1:0]  R,
  input  logic [1:0]  G,
  input  logic [1:0]  B,
  output logic [5:0]  pix,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [15:0] blank_err_cnt
);

  localparam logic [11:0] L_HA0  = 12'(H_PULSE + H_BPORCH);
  localparam logic [11:0] L_HA1  = 12'(H_PULSE + H_BPORCH + H_PIXELS - 1);
  localparam logic [10:0] L_VA0  = 11'(V_PULSE + V_BPORCH);
  localparam logic [10:0] L_VA1  = 11'(V_PULSE + V_BPORCH + V_PIXELS - 1);
  localparam logic [12:0] L_HPER = 13'(H_PERIOD);
  localparam logic [11:0] L_HTO  = 12'(2 * H_PERIOD);
  localparam logic [11:0] L_VPER = 12'(V_PERIOD);
  localparam logic [3:0]  L_LOCK = 4'(LOCK_FRAMES);
  localparam logic        L_HPOL = (H_POLAR != 0);
  localparam logic        L_VPOL = (V_POLAR != 0);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // True when a (pixel, line) counter pair lies inside the active window.
  function automatic logic f_in_win(input logic [11:0] hc, input logic [10:0] vc);
    f_in_win = (hc >= L_HA0) && (hc <= L_HA1) && (vc >= L_VA0) && (vc <= L_VA1);
  endfunction

  logic        r_hs1, r_vs1, r_hs1_d, r_vs1_d;
  logic [5:0]  r_rgb1, r_rgb2;
  logic [11:0] r_hc, w_hc_nx;
  logic [10:0] r_vc, w_vc_nx;
  logic        w_h_edge, w_v_edge;
  logic        w_line_err, w_frame_err, w_any_err;
  state_t      r_state, w_state_nx;
  logic [3:0]  r_good, w_good_nx, w_good_inc;
  logic        w_valid;
  logic [9:0]  w_x;
  logic [8:0]  w_y;

  // Stage 1: sample syncs (normalised to active-high) and RGB, keep previous sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
      r_hs1_d <= 1'b0;
      r_vs1_d <= 1'b0;
      r_rgb1  <= 6'd0;
    end else begin
      r_hs1   <= h_sync ^ L_HPOL;
      r_vs1   <= v_sync ^ L_VPOL;
      r_hs1_d <= r_hs1;
      r_vs1_d <= r_vs1;
      r_rgb1  <= {R, G, B};
    end
  end

  assign w_h_edge = r_hs1 & ~r_hs1_d;
  assign w_v_edge = r_vs1 & ~r_vs1_d;

  // Counter values belonging to the current stage-1 sample.
  always_comb begin
    w_hc_nx = r_hc;
    w_vc_nx = r_vc;
    if (w_h_edge) begin
      w_hc_nx = 12'd0;
    end else if (r_hc != 12'hFFF) begin
      w_hc_nx = r_hc + 12'd1;
    end else begin
      w_hc_nx = r_hc;
    end
    if (w_v_edge) begin
      w_vc_nx = 11'd0;
    end else if (w_h_edge && (r_vc != 11'h7FF)) begin
      w_vc_nx = r_vc + 11'd1;
    end else begin
      w_vc_nx = r_vc;
    end
  end

  // Previous line length is r_hc+1; a missing edge is caught once at 2*H_PERIOD.
  assign w_line_err  = (w_h_edge && (({1'b0, r_hc} + 13'd1) != L_HPER)) ||
                       (!w_h_edge && (w_hc_nx == L_HTO));
  assign w_frame_err = w_v_edge && (({1'b0, r_vc} + 12'd1) != L_VPER);
  assign w_any_err   = w_line_err | w_frame_err;
  assign w_good_inc  = r_good + 4'd1;

  // Stage 2: counters and colour follow the stage-1 sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc   <= 12'd0;
      r_vc   <= 11'd0;
      r_rgb2 <= 6'd0;
    end else begin
      r_hc   <= w_hc_nx;
      r_vc   <= w_vc_nx;
      r_rgb2 <= r_rgb1;
    end
  end

  // Lock FSM state and good-frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SEARCH;
      r_good  <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_good  <= w_good_nx;
    end
  end

  // Lock FSM next state: any timing error while verifying/locked drops to SEARCH.
  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good;
    case (r_state)
      ST_SEARCH: begin
        if (w_v_edge) begin
          w_state_nx = ST_VERIFY;
          w_good_nx  = 4'd0;
        end else begin
          w_state_nx = ST_SEARCH;
        end
      end
      ST_VERIFY: begin
        if (w_any_err) begin
          w_state_nx = ST_SEARCH;
          w_good_nx  = 4'd0;
        end else if (w_v_edge) begin
          w_good_nx = w_good_inc;
          if (w_good_inc >= L_LOCK) begin
            w_state_nx = ST_LOCKED;
          end else begin
            w_state_nx = ST_VERIFY;
          end
        end else begin
          w_state_nx = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        if (w_any_err) begin
          w_state_nx = ST_SEARCH;
          w_good_nx  = 4'd0;
        end else begin
          w_state_nx = ST_LOCKED;
        end
      end
      default: begin
        w_state_nx = ST_SEARCH;
        w_good_nx  = 4'd0;
      end
    endcase
  end

  // Sticky error flags, only armed once the FSM has left SEARCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_h <= 1'b0;
      err_v <= 1'b0;
    end else begin
      if ((r_state != ST_SEARCH) && w_line_err) begin
        err_h <= 1'b1;
      end
      if ((r_state != ST_SEARCH) && w_frame_err) begin
        err_v <= 1'b1;
      end
    end
  end

  assign w_valid = (r_state == ST_LOCKED) && f_in_win(r_hc, r_vc);
  assign w_x     = 10'(r_hc - L_HA0);
  assign w_y     = 9'(r_vc - L_VA0);

  // Stage 3: output register; pix/x/y hold their last value outside valid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix         <= 6'd0;
      x           <= 10'd0;
      y           <= 9'd0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      locked      <= (r_state == ST_LOCKED);
      pix_valid   <= w_valid;
      frame_start <= w_valid && (w_x == 10'd0) && (w_y == 9'd0);
      if (w_valid) begin
        pix <= r_rgb2;
        x   <= w_x;
        y   <= w_y;
      end
    end
  end

`ifdef VGA_CAPTURE_BLANK_CHECK_EN
  logic w_blank_hit;
  assign w_blank_hit = (r_state == ST_LOCKED) && !f_in_win(w_hc_nx, w_vc_nx) &&
                       (r_rgb1 != 6'd0);

  // Saturating count of non-black samples in blanking while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_err_cnt <= 16'd0;
    end else if (w_blank_hit && (blank_err_cnt != 16'hFFFF)) begin
      blank_err_cnt <= blank_err_cnt + 16'd1;
    end
  end
`else
  assign blank_err_cnt = 16'd0;
`endif

endmodule
